// File: rtl/alu_pkg.sv
// Shared opcode map and flag bit positions for the pipelined ALU.
// The opcode encodings match the original 8-bit combinational ALU mux.
package alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_INC   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_XOR   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;
  localparam logic [2:0] OP_RSVD6 = 3'b110;
  localparam logic [2:0] OP_RSVD7 = 3'b111;

  localparam int unsigned FLG_Z = 0;
  localparam int unsigned FLG_N = 1;
  localparam int unsigned FLG_C = 2;
  localparam int unsigned FLG_V = 3;

  function automatic logic is_rsvd(input logic [2:0] op);
    return (op == OP_RSVD6) || (op == OP_RSVD7);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: result, {V,C,N,Z} flags and opcode error.
// Arithmetic runs at WIDTH+1 bits so the top bit is the carry/borrow.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SAT_EN = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             op_err
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH:0]   raw;
  logic [WIDTH-1:0] res;
  logic             c;
  logic             v;

  always_comb begin
    raw    = '0;
    res    = '0;
    c      = 1'b0;
    v      = 1'b0;
    op_err = 1'b0;
    case (op)
      OP_ADD: begin
        raw = {1'b0, a} + {1'b0, b};
        c   = raw[WIDTH];
        v   = (a[MSB] == b[MSB]) && (raw[MSB] != a[MSB]);
        res = (SAT_EN && c) ? '1 : raw[WIDTH-1:0];
      end
      OP_INC: begin
        raw = {1'b0, a} + (WIDTH+1)'(1);
        c   = raw[WIDTH];
        // the constant 1 is non-negative, so only a positive A can overflow
        v   = !a[MSB] && raw[MSB];
        res = (SAT_EN && c) ? '1 : raw[WIDTH-1:0];
      end
      OP_SUB: begin
        raw = {1'b0, a} - {1'b0, b};
        c   = raw[WIDTH];
        v   = (a[MSB] != b[MSB]) && (raw[MSB] != a[MSB]);
        res = (SAT_EN && c) ? '0 : raw[WIDTH-1:0];
      end
      OP_XOR: res = a ^ b;
      OP_OR:  res = a | b;
      OP_AND: res = a & b;
      default: begin
        op_err = is_rsvd(op);
        res    = '0;
      end
    endcase
  end

  always_comb begin
    flags        = '0;
    flags[FLG_Z] = (res == '0);
    flags[FLG_N] = res[MSB];
    flags[FLG_C] = c;
    flags[FLG_V] = v;
  end

  assign result = res;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, accumulator and status flags.
// One-cycle latency; the only combinational path is out_ready -> in_ready.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          SAT_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_use_acc,
  input  logic             in_acc_wr,
  input  logic             acc_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_op_err,
  output logic [WIDTH-1:0] acc_value
);

  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] core_result;
  logic [3:0]       core_flags;
  logic             core_err;
  logic [WIDTH-1:0] acc;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // acc is the pre-edge value, so a dependent op right after a write sees it
  assign op_a     = in_use_acc ? acc : in_a;

  alu_core #(
    .WIDTH  (WIDTH),
    .SAT_EN (SAT_EN)
  ) u_core (
    .a      (op_a),
    .b      (in_b),
    .op     (in_op),
    .result (core_result),
    .flags  (core_flags),
    .op_err (core_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      out_op_err <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_result <= core_result;
      out_flags  <= core_flags;
      out_op_err <= core_err;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_clear) begin
      acc <= '0;
    end else if (accept && in_acc_wr) begin
      acc <= core_result;
    end
  end

  assign acc_value = acc;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a wrapping and a saturating instance share stimulus.
// Expected results come from an integer-arithmetic model of the opcode rules.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_use_acc, in_acc_wr, acc_clear, out_ready;
  logic [7:0] in_a, in_b;
  logic [2:0] in_op;

  logic       rdy0, ov0, err0, rdy1, ov1, err1;
  logic [7:0] res0, acc0, res1, acc1;
  logic [3:0] fl0, fl1;

  typedef struct packed {
    logic       err;
    logic [3:0] f;
    logic [7:0] r;
  } res_t;

  typedef struct packed {
    res_t w;
    res_t s;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mov = 0;
  logic [7:0] macc_w = 0, macc_s = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8), .SAT_EN(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_use_acc(in_use_acc),
    .in_acc_wr(in_acc_wr), .acc_clear(acc_clear), .out_valid(ov0),
    .out_ready(out_ready), .out_result(res0), .out_flags(fl0),
    .out_op_err(err0), .acc_value(acc0)
  );

  alu_pipe #(.WIDTH(8), .SAT_EN(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_use_acc(in_use_acc),
    .in_acc_wr(in_acc_wr), .acc_clear(acc_clear), .out_valid(ov1),
    .out_ready(out_ready), .out_result(res1), .out_flags(fl1),
    .out_op_err(err1), .acc_value(acc1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the opcode table evaluated with plain integers on 8-bit operands
  function automatic res_t model(input int a, input int b, input int op, input bit sat);
    res_t o;
    int   r = 0;
    bit   c = 0, v = 0, err = 0;
    if (op == 1) begin
      b  = 1;
      op = 0;
    end
    case (op)
      0: begin
        r = a + b;
        c = (r > 255);
        r = r % 256;
        v = ((a >= 128) == (b >= 128)) && ((r >= 128) != (a >= 128));
        if (sat && c) r = 255;
      end
      2: begin
        c = (a < b);
        r = (a - b + 256) % 256;
        v = ((a >= 128) != (b >= 128)) && ((r >= 128) != (a >= 128));
        if (sat && c) r = 0;
      end
      3: r = a ^ b;
      4: r = a | b;
      5: r = a & b;
      default: begin
        r   = 0;
        err = 1;
      end
    endcase
    o.err = err;
    o.r   = 8'(r);
    o.f   = {v, c, (r >= 128), (r == 0)};
    return o;
  endfunction

  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input logic ua, input logic aw,
                      input logic clr, input logic ordy);
    bit   accept;
    exp_t e;
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; in_op = op;
    in_use_acc = ua; in_acc_wr = aw; acc_clear = clr; out_ready = ordy;
    #1;
    chk("in_ready_wrap", 32'(rdy0), 32'(!mov || ordy));
    chk("in_ready_sat", 32'(rdy1), 32'(!mov || ordy));
    chk("out_valid_wrap", 32'(ov0), 32'(mov));
    chk("out_valid_sat", 32'(ov1), 32'(mov));
    chk("acc_wrap", 32'(acc0), 32'(macc_w));
    chk("acc_sat", 32'(acc1), 32'(macc_s));
    accept = v && (!mov || ordy);
    if (accept) begin
      e.w = model(int'(ua ? macc_w : a), int'(b), int'(op), 1'b0);
      e.s = model(int'(ua ? macc_s : a), int'(b), int'(op), 1'b1);
      q.push_back(e);
      if (aw) begin
        macc_w = e.w.r;
        macc_s = e.s.r;
      end
    end
    if (clr) begin
      macc_w = 0;
      macc_s = 0;
    end
    mov = accept || (mov && !ordy);
  endtask

  // Monitor: runs after inputs settle, before the edge that consumes the result
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && ov0 === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'(res0), 32'hFFFF_FFFF);
        end else begin
          e = q[0];
          chk("result_wrap", 32'(res0), 32'(e.w.r));
          chk("flags_wrap", 32'(fl0), 32'(e.w.f));
          chk("err_wrap", 32'(err0), 32'(e.w.err));
          chk("result_sat", 32'(res1), 32'(e.s.r));
          chk("flags_sat", 32'(fl1), 32'(e.s.f));
          chk("err_sat", 32'(err1), 32'(e.s.err));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_a = 0; in_b = 0; in_op = 0;
    in_use_acc = 0; in_acc_wr = 0; acc_clear = 0; out_ready = 0;
    #1;
    chk("rst_out_valid", 32'(ov0), 32'd0);
    chk("rst_result", 32'(res1), 32'd0);
    chk("rst_flags", 32'(fl0), 32'd0);
    chk("rst_acc", 32'(acc0), 32'd0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;

    // Arithmetic corner cases
    step(1, 8'hF0, 8'h20, 3'd0, 0, 0, 0, 1);
    step(1, 8'h05, 8'h09, 3'd2, 0, 0, 0, 1);
    step(1, 8'h7F, 8'h01, 3'd0, 0, 0, 0, 1);
    step(1, 8'h80, 8'h01, 3'd2, 0, 0, 0, 1);
    step(1, 8'hFF, 8'h00, 3'd1, 0, 0, 0, 1);
    step(1, 8'h12, 8'h34, 3'd7, 0, 0, 0, 1);
    step(1, 8'h55, 8'h00, 3'd4, 0, 1, 0, 1);
    step(1, 8'h12, 8'h34, 3'd6, 0, 1, 0, 1);
    step(1, 8'hA5, 8'h3C, 3'd3, 0, 0, 0, 1);
    step(1, 8'hA5, 8'h3C, 3'd5, 0, 0, 0, 1);

    // Backpressure: second op waits while the first result is held
    step(1, 8'h11, 8'h22, 3'd4, 0, 0, 0, 0);
    repeat (5) step(1, 8'h33, 8'h0F, 3'd5, 0, 0, 0, 0);
    step(1, 8'h33, 8'h0F, 3'd5, 0, 0, 0, 1);
    step(0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 1);

    // Accumulator chain, then clear winning over a simultaneous write
    step(0, 8'h00, 8'h00, 3'd0, 0, 0, 1, 1);
    repeat (3) step(1, 8'hEE, 8'h00, 3'd1, 1, 1, 0, 1);
    step(0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 1);
    step(1, 8'h44, 8'h00, 3'd4, 0, 1, 1, 1);
    step(0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 1);

    // Asynchronous reset while a result is held and acc=0x55
    step(1, 8'h55, 8'h00, 3'd4, 0, 1, 0, 1);
    step(1, 8'h12, 8'h34, 3'd3, 0, 0, 0, 0);
    step(1, 8'h01, 8'h01, 3'd0, 0, 0, 0, 0);
    chk("pre_rst_acc", 32'(acc0), 32'h55);
    @(negedge clk);
    in_valid = 0; out_ready = 0;
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(ov0), 32'd0);
    chk("async_rst_result", 32'(res0), 32'd0);
    chk("async_rst_acc", 32'(acc0), 32'd0);
    chk("async_rst_acc_sat", 32'(acc1), 32'd0);
    q.delete();
    mov = 0; macc_w = 0; macc_s = 0;
    @(negedge clk);
    #3 rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 8), 8'($urandom), 8'($urandom),
           3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
    end

    repeat (5) step(0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 1);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
